contador_bcd_ndigitos: RTL and testbench

Parametrised N-digit BCD counter, successor of the fixed 3-digit counter. It counts up or down, loads a parallel BCD value and flags the terminal count. It also emits a one-cycle pulse on wrap (or on an overflow attempt when saturation is compiled in). It drives the display/timing datapaths that the 3-digit version served; DIGITS=3 with sentido=1 reproduces the old count sequence.

---
 rtl/contador_bcd_pkg.sv | 53 +++++
 rtl/contador_bcd_digito.sv | 46 ++++
 rtl/contador_bcd_ndigitos.sv | 76 +++++++
 tb/tb_contador_bcd_ndigitos.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/contador_bcd_pkg.sv
// Shared definitions for the N-digit BCD counter.
// Digit range limits, load clamp and per-digit operation decode.
package contador_bcd_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_STEP
  } op_e;

  function automatic logic [BCD_W-1:0] bcd_clamp(
    input logic [BCD_W-1:0] v
  );
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_inc(
    input logic [BCD_W-1:0] v
  );
    return (v >= BCD_MAX) ? BCD_MIN : v + 4'd1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(
    input logic [BCD_W-1:0] v
  );
    return (v == BCD_MIN) ? BCD_MAX : v - 4'd1;
  endfunction

  // Clear beats load, load beats counting.
  function automatic op_e op_decode(
    input logic zera,
    input logic carrega,
    input logic en
  );
    op_e op;
    op = OP_HOLD;
    if (zera) begin
      op = OP_CLR;
    end else if (carrega) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_STEP;
    end
    return op;
  endfunction

endpackage

// File: rtl/contador_bcd_digito.sv
// One BCD digit of the chained counter.
// term flags 9 when counting up, 0 when counting down.
module contador_bcd_digito
  import contador_bcd_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             zera,
  input  logic             carrega,
  input  logic [BCD_W-1:0] dado_digito,
  input  logic             en,
  input  logic             sentido,
  output logic [BCD_W-1:0] digito,
  output logic             term
);

  logic [BCD_W-1:0] digito_q;
  logic [BCD_W-1:0] digito_d;
  op_e              op;

  assign op = op_decode(zera, carrega, en);

  always_comb begin
    digito_d = digito_q;
    unique case (op)
      OP_CLR:  digito_d = BCD_MIN;
      OP_LOAD: digito_d = bcd_clamp(dado_digito);
      OP_STEP: digito_d = sentido ? bcd_inc(digito_q)
                                  : bcd_dec(digito_q);
      default: digito_d = digito_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      digito_q <= BCD_MIN;
    end else begin
      digito_q <= digito_d;
    end
  end

  assign digito = digito_q;
  assign term   = sentido ? (digito_q == BCD_MAX)
                          : (digito_q == BCD_MIN);

endmodule

// File: rtl/contador_bcd_ndigitos.sv
// Parametrised N-digit BCD up/down counter with load and wrap pulse.
// Define CONTADOR_BCD_SATURA_EN to saturate at the limits instead of wrapping.
module contador_bcd_ndigitos
  import contador_bcd_pkg::*;
#(
  parameter int DIGITS = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  zera,
  input  logic                  carrega,
  input  logic [4*DIGITS-1:0]   dado,
  input  logic                  conta,
  input  logic                  sentido,
  output logic [4*DIGITS-1:0]   digitos,
  output logic                  fim,
  output logic                  estouro
);

  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] en;
  logic              passo;
  logic              estouro_q;
  logic              estouro_d;

`ifdef CONTADOR_BCD_SATURA_EN
  assign passo = conta & ~fim;
`else
  assign passo = conta;
`endif

  // Ripple carry/borrow: a digit steps when every lower digit is at its limit.
  always_comb begin
    logic c;
    c  = passo;
    en = '0;
    for (int k = 0; k < DIGITS; k++) begin
      en[k] = c;
      c     = c & term[k];
    end
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    contador_bcd_digito u_dig (
      .clock       (clock),
      .reset       (reset),
      .zera        (zera),
      .carrega     (carrega),
      .dado_digito (dado[BCD_W*k +: BCD_W]),
      .en          (en[k]),
      .sentido     (sentido),
      .digito      (digitos[BCD_W*k +: BCD_W]),
      .term        (term[k])
    );
  end

  assign fim = &term;

  always_comb begin
    estouro_d = 1'b0;
    if (!zera && !carrega) begin
      estouro_d = conta & fim;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estouro_q <= 1'b0;
    end else begin
      estouro_q <= estouro_d;
    end
  end

  assign estouro = estouro_q;

endmodule

// File: tb/tb_contador_bcd_ndigitos.sv
// Self-checking bench for contador_bcd_ndigitos (DIGITS=3).
// Integer reference model plus a vector table and directed corners.
module tb_contador_bcd_ndigitos;

  localparam int D    = 3;
  localparam int MAXV = 999;

  logic           clock;
  logic           reset;
  logic           zera;
  logic           carrega;
  logic [4*D-1:0] dado;
  logic           conta;
  logic           sentido;
  logic [4*D-1:0] digitos;
  logic           fim;
  logic           estouro;

  int total;
  int bad;
  int v;
  bit e;

  contador_bcd_ndigitos #(.DIGITS(D)) dut (
    .clock   (clock),
    .reset   (reset),
    .zera    (zera),
    .carrega (carrega),
    .dado    (dado),
    .conta   (conta),
    .sentido (sentido),
    .digitos (digitos),
    .fim     (fim),
    .estouro (estouro)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit             z;
    bit             c;
    logic [4*D-1:0] d;
    bit             k;
    bit             s;
    logic [4*D-1:0] xd;
    bit             xf;
    bit             xe;
  } vec_t;

  function automatic int clampv(logic [4*D-1:0] d);
    int r;
    int p;
    int nib;
    r = 0;
    p = 1;
    for (int k = 0; k < D; k++) begin
      nib = int'(d[4*k +: 4]);
      if (nib > 9) nib = 9;
      r += nib * p;
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [4*D-1:0] tobcd(int x);
    logic [4*D-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit fimm(int val, bit s);
    return s ? (val == MAXV) : (val == 0);
  endfunction

  task automatic chk(string nm, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic drive(bit z, bit c, logic [4*D-1:0] d, bit k, bit s);
    zera    = z;
    carrega = c;
    dado    = d;
    conta   = k;
    sentido = s;
  endtask

  task automatic model_edge();
    bit f;
    if (zera) begin
      v = 0;
      e = 0;
    end else if (carrega) begin
      v = clampv(dado);
      e = 0;
    end else if (conta) begin
      f = fimm(v, sentido);
      e = f;
`ifdef CONTADOR_BCD_SATURA_EN
      if (!f) v = sentido ? v + 1 : v - 1;
`else
      v = sentido ? (v + 1) % (MAXV + 1) : (v + MAXV) % (MAXV + 1);
`endif
    end else begin
      e = 0;
    end
  endtask

  task automatic tick_check(string nm);
    model_edge();
    @(posedge clock);
    #1;
    chk({nm, "_dig"}, int'(digitos), int'(tobcd(v)));
    chk({nm, "_est"}, int'(estouro), int'(e));
    chk({nm, "_fim"}, int'(fim), int'(fimm(v, sentido)));
  endtask

  vec_t tbl[14];
  int   n_est;
  int   n_fim;

  initial begin
    total = 0;
    bad   = 0;
    v     = 0;
    e     = 0;
    reset = 1'b0;
    drive(0, 0, '0, 0, 1);

    // reset state
    #2;
    chk("rst_dig", int'(digitos), 0);
    chk("rst_est", int'(estouro), 0);
    chk("rst_fim_up", int'(fim), 0);
    sentido = 1'b0;
    #1;
    chk("rst_fim_dn", int'(fim), 1);

    @(negedge clock);
    reset = 1'b1;
    drive(0, 0, '0, 1, 1);

    // full up sweep with wrap
    n_est = 0;
    n_fim = 0;
    for (int i = 0; i < 1005; i++) begin
      tick_check("sweep");
      if (estouro) n_est++;
      if (fim) n_fim++;
    end
`ifdef CONTADOR_BCD_SATURA_EN
    chk("sweep_end", int'(digitos), 'h999);
    chk("sweep_nest", n_est, 6);
    chk("sweep_nfim", n_fim, 7);
`else
    chk("sweep_end", int'(digitos), 'h005);
    chk("sweep_nest", n_est, 1);
    chk("sweep_nfim", n_fim, 1);
`endif

    // vector table: load clamp, priority, wrap/saturate corners
    tbl[0]  = '{0, 1, 12'h0C7, 0, 1, 12'h097, 0, 0};
    tbl[1]  = '{0, 0, 12'h000, 1, 1, 12'h098, 0, 0};
    tbl[2]  = '{0, 0, 12'h000, 1, 1, 12'h099, 0, 0};
    tbl[3]  = '{0, 0, 12'h000, 1, 1, 12'h100, 0, 0};
    tbl[4]  = '{0, 1, 12'h058, 0, 1, 12'h058, 0, 0};
    tbl[5]  = '{1, 1, 12'h321, 1, 1, 12'h000, 0, 0};
    tbl[6]  = '{0, 1, 12'h321, 1, 1, 12'h321, 0, 0};
    tbl[7]  = '{0, 1, 12'hFAF, 0, 1, 12'h999, 1, 0};
`ifdef CONTADOR_BCD_SATURA_EN
    tbl[8]  = '{0, 0, 12'h000, 1, 1, 12'h999, 1, 1};
    tbl[9]  = '{0, 0, 12'h000, 1, 0, 12'h998, 0, 0};
    tbl[10] = '{0, 1, 12'h000, 0, 0, 12'h000, 1, 0};
    tbl[11] = '{0, 0, 12'h000, 1, 0, 12'h000, 1, 1};
    tbl[12] = '{0, 0, 12'h000, 1, 0, 12'h000, 1, 1};
    tbl[13] = '{0, 0, 12'h000, 0, 0, 12'h000, 1, 0};
`else
    tbl[8]  = '{0, 0, 12'h000, 1, 1, 12'h000, 0, 1};
    tbl[9]  = '{0, 0, 12'h000, 1, 0, 12'h999, 0, 1};
    tbl[10] = '{0, 1, 12'h000, 0, 0, 12'h000, 1, 0};
    tbl[11] = '{0, 0, 12'h000, 1, 0, 12'h999, 0, 1};
    tbl[12] = '{0, 0, 12'h000, 1, 0, 12'h998, 0, 0};
    tbl[13] = '{0, 0, 12'h000, 0, 0, 12'h998, 0, 0};
`endif
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].z, tbl[i].c, tbl[i].d, tbl[i].k, tbl[i].s);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_dig", i), int'(digitos), int'(tbl[i].xd));
      chk($sformatf("tbl%0d_fim", i), int'(fim), int'(tbl[i].xf));
      chk($sformatf("tbl%0d_est", i), int'(estouro), int'(tbl[i].xe));
    end

    // fim before the edge when loaded 000 and counting down
    drive(1, 0, '0, 0, 0);
    tick_check("sync0");
    drive(0, 0, '0, 1, 0);
    #1;
    chk("pre_fim_dn", int'(fim), 1);
    tick_check("dn_wrap");
    tick_check("dn_next");

    // limit sequence from 998 upward then reverse
    drive(0, 1, 12'h998, 0, 1);
    tick_check("lim_ld");
    drive(0, 0, '0, 1, 1);
    for (int i = 0; i < 4; i++) tick_check("lim_up");
    sentido = 1'b0;
    tick_check("lim_rev");

    // async reset mid-cycle at 437
    drive(0, 1, 12'h437, 0, 1);
    tick_check("r437_ld");
    drive(0, 0, '0, 0, 1);
    #3;
    reset   = 1'b0;
    sentido = 1'b0;
    #1;
    chk("r437_dig", int'(digitos), 0);
    chk("r437_est", int'(estouro), 0);
    chk("r437_fim", int'(fim), 1);
    @(negedge clock);
    reset = 1'b1;
    v = 0;
    e = 0;

    // async reset kills a live estouro pulse
    drive(0, 1, 12'h999, 0, 1);
    tick_check("rest_ld");
    drive(0, 0, '0, 1, 1);
    tick_check("rest_wr");
    drive(0, 0, '0, 0, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("rest_est", int'(estouro), 0);
    chk("rest_dig", int'(digitos), 0);
    @(negedge clock);
    reset = 1'b1;
    v = 0;
    e = 0;

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      r       = int'($urandom_range(0, 99));
      zera    = (r < 3);
      carrega = (r >= 3 && r < 12);
      case ($urandom_range(0, 3))
        0: dado = 12'h999;
        1: dado = 12'h000;
        default: dado = 12'($urandom);
      endcase
      conta = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) sentido = ~sentido;
      #1;
      chk("rnd_prefim", int'(fim), int'(fimm(v, sentido)));
      tick_check("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
